// File: rtl/snake_dir_input.sv
// PS/2 receiver that latches arrow-key make codes into a held snake direction (1 up, 2 right, 3 down, 4 left).
// move/key_valid update one cycle after the stop-bit edge; `SNAKE_WASD_EN also maps plain W/A/S/D codes.
module snake_dir_input #(
    parameter int RESET_DIR      = 2,
    parameter int TIMEOUT_CYCLES = 50000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        ps2_clk,
    input  logic        ps2_data,
    output logic [31:0] move,
    output logic        key_valid,
    output logic [7:0]  scancode,
    output logic        frame_err
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

    state_t        state_q;
    logic          clk_s1_q, clk_s2_q, clk_prev_q;
    logic          dat_s1_q, dat_s2_q;
    logic [2:0]    bit_cnt_q;
    logic [7:0]    shift_q;
    logic          par_ok_q;
    logic [TW-1:0] to_cnt_q;
    logic          ext_q, brk_q;
    logic [2:0]    move_q;
    logic          key_valid_q, frame_err_q;
    logic [7:0]    scancode_q;

    logic          fall;
    logic          ext_d, brk_d;
    logic          cand_vld;
    logic [2:0]    cand_dir;
    logic [1:0]    rel;
    logic [2:0]    move_d;

    assign fall = clk_prev_q & ~clk_s2_q;

    // Decode of the byte currently held in shift_q; only applied when the frame is accepted.
    always_comb begin
        ext_d    = ext_q;
        brk_d    = brk_q;
        cand_vld = 1'b0;
        cand_dir = 3'd0;
        if (shift_q == 8'hE0) begin
            ext_d = 1'b1;
        end else if (shift_q == 8'hF0) begin
            brk_d = 1'b1;
        end else begin
            ext_d = 1'b0;
            brk_d = 1'b0;
            if (!brk_q) begin
                if (ext_q) begin
                    case (shift_q)
                        8'h75:   begin cand_vld = 1'b1; cand_dir = 3'd1; end
                        8'h74:   begin cand_vld = 1'b1; cand_dir = 3'd2; end
                        8'h72:   begin cand_vld = 1'b1; cand_dir = 3'd3; end
                        8'h6B:   begin cand_vld = 1'b1; cand_dir = 3'd4; end
                        default: ;
                    endcase
                end else begin
`ifdef SNAKE_WASD_EN
                    case (shift_q)
                        8'h1D:   begin cand_vld = 1'b1; cand_dir = 3'd1; end
                        8'h23:   begin cand_vld = 1'b1; cand_dir = 3'd2; end
                        8'h1B:   begin cand_vld = 1'b1; cand_dir = 3'd3; end
                        8'h1C:   begin cand_vld = 1'b1; cand_dir = 3'd4; end
                        default: ;
                    endcase
`endif
                end
            end
        end
        // Opposite directions differ by exactly 2 modulo 4.
        rel    = cand_dir[1:0] - move_q[1:0];
        move_d = (cand_vld && rel != 2'b10) ? cand_dir : move_q;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clk_s1_q    <= 1'b1;
            clk_s2_q    <= 1'b1;
            clk_prev_q  <= 1'b1;
            dat_s1_q    <= 1'b1;
            dat_s2_q    <= 1'b1;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            par_ok_q    <= 1'b0;
            to_cnt_q    <= '0;
            ext_q       <= 1'b0;
            brk_q       <= 1'b0;
            move_q      <= 3'(RESET_DIR);
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
            scancode_q  <= 8'd0;
        end else begin
            clk_s1_q    <= ps2_clk;
            clk_s2_q    <= clk_s1_q;
            clk_prev_q  <= clk_s2_q;
            dat_s1_q    <= ps2_data;
            dat_s2_q    <= dat_s1_q;
            key_valid_q <= 1'b0;
            frame_err_q <= 1'b0;

            if (state_q == S_IDLE || fall) to_cnt_q <= '0;
            else                           to_cnt_q <= to_cnt_q + 1'b1;

            if (state_q != S_IDLE && to_cnt_q == TW'(TIMEOUT_CYCLES)) begin
                frame_err_q <= 1'b1;
                state_q     <= S_IDLE;
            end else if (fall) begin
                case (state_q)
                    S_IDLE: begin
                        if (!dat_s2_q) begin
                            state_q   <= S_DATA;
                            bit_cnt_q <= 3'd0;
                        end
                    end
                    S_DATA: begin
                        shift_q   <= {dat_s2_q, shift_q[7:1]};
                        bit_cnt_q <= bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) state_q <= S_PARITY;
                    end
                    S_PARITY: begin
                        par_ok_q <= (^shift_q) ^ dat_s2_q;
                        state_q  <= S_STOP;
                    end
                    S_STOP: begin
                        if (dat_s2_q && par_ok_q) begin
                            key_valid_q <= 1'b1;
                            scancode_q  <= shift_q;
                            ext_q       <= ext_d;
                            brk_q       <= brk_d;
                            move_q      <= move_d;
                        end else begin
                            frame_err_q <= 1'b1;
                        end
                        state_q <= S_IDLE;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign move      = {29'd0, move_q};
    assign key_valid = key_valid_q;
    assign scancode  = scancode_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_snake_dir_input.sv
// Directed plus randomized PS/2 frames against a behavioural direction model.
module tb_snake_dir_input;

    logic        clock = 1'b0;
    logic        reset;
    logic        ps2_clk;
    logic        ps2_data;
    logic [31:0] move;
    logic        key_valid;
    logic [7:0]  scancode;
    logic        frame_err;

    always #5 clock = ~clock;

    snake_dir_input dut (
        .clock     (clock),
        .reset     (reset),
        .ps2_clk   (ps2_clk),
        .ps2_data  (ps2_data),
        .move      (move),
        .key_valid (key_valid),
        .scancode  (scancode),
        .frame_err (frame_err)
    );

    int vectors     = 0;
    int miscompares = 0;
    int kv_seen     = 0;
    int fe_seen     = 0;
    int kv_exp      = 0;
    int fe_exp      = 0;

    int         m_move;
    bit         m_ext, m_brk;
    logic [7:0] m_scan;

    // Each high cycle counts, so a stuck-high pulse shows up as a count mismatch.
    always @(negedge clock) begin
        if (key_valid) kv_seen++;
        if (frame_err) fe_seen++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int opposite(input int d);
        return ((d + 1) % 4) + 1;
    endfunction

    function automatic int key_dir(input logic [7:0] b, input bit ext);
        if (ext) begin
            if (b == 8'h75) return 1;
            if (b == 8'h74) return 2;
            if (b == 8'h72) return 3;
            if (b == 8'h6B) return 4;
            return 0;
        end
`ifdef SNAKE_WASD_EN
        if (b == 8'h1D) return 1;
        if (b == 8'h23) return 2;
        if (b == 8'h1B) return 3;
        if (b == 8'h1C) return 4;
`endif
        return 0;
    endfunction

    task automatic model_reset();
        m_move = 2;
        m_ext  = 1'b0;
        m_brk  = 1'b0;
        m_scan = 8'h00;
    endtask

    task automatic model_accept(input logic [7:0] b);
        int d;
        kv_exp++;
        m_scan = b;
        if (b == 8'hE0) m_ext = 1'b1;
        else if (b == 8'hF0) m_brk = 1'b1;
        else begin
            d = m_brk ? 0 : key_dir(b, m_ext);
            if (d != 0 && d != opposite(m_move)) m_move = d;
            m_ext = 1'b0;
            m_brk = 1'b0;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_kv"},   kv_seen,  kv_exp);
        chk({tag, "_fe"},   fe_seen,  fe_exp);
        chk({tag, "_scan"}, {24'd0, scancode}, {24'd0, m_scan});
        chk({tag, "_move"}, move,     m_move);
    endtask

    task automatic ps2_bit(input logic b);
        ps2_data = b;
        repeat (4) @(posedge clock);
        ps2_clk = 1'b0;
        repeat (4) @(posedge clock);
        ps2_clk = 1'b1;
    endtask

    task automatic send_frame(input string tag, input logic [7:0] b, input bit bad_par, input bit bad_stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(b[i]);
        ps2_bit((~^b) ^ bad_par);
        ps2_bit(~bad_stop);
        ps2_data = 1'b1;
        repeat (20) @(posedge clock);
        if (!bad_par && !bad_stop) model_accept(b);
        else fe_exp++;
        @(negedge clock);
        check_all(tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    logic [7:0] pool [12];

    initial begin
        pool = '{8'hE0, 8'hE0, 8'hF0, 8'h75, 8'h74, 8'h72, 8'h6B,
                 8'h1D, 8'h23, 8'h1B, 8'h1C, 8'h29};
        reset    = 1'b1;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        model_reset();
        repeat (3) @(posedge clock);
        @(negedge clock);
        chk("rst_hold_move", move, 32'd2);
        chk("rst_hold_kv", {31'd0, key_valid}, 32'd0);
        reset = 1'b0;
        repeat (10) @(posedge clock);
        @(negedge clock);
        chk("idle_fe", {31'd0, frame_err}, 32'd0);
        check_all("idle");

        send_frame("up_e0", 8'hE0, 0, 0);
        send_frame("up_75", 8'h75, 0, 0);
        send_frame("rev_e0", 8'hE0, 0, 0);
        send_frame("rev_72", 8'h72, 0, 0);
        send_frame("left_e0", 8'hE0, 0, 0);
        send_frame("left_6b", 8'h6B, 0, 0);
        send_frame("rel_e0", 8'hE0, 0, 0);
        send_frame("rel_f0", 8'hF0, 0, 0);
        send_frame("rel_6b", 8'h6B, 0, 0);
        send_frame("right_e0", 8'hE0, 0, 0);
        send_frame("right_74", 8'h74, 0, 0);
        send_frame("down_e0", 8'hE0, 0, 0);
        send_frame("down_72", 8'h72, 0, 0);
        send_frame("badpar", 8'h75, 1, 0);
        send_frame("badstop", 8'h74, 0, 1);
        send_frame("l2_e0", 8'hE0, 0, 0);
        send_frame("l2_6b", 8'h6B, 0, 0);
        send_frame("u2_e0", 8'hE0, 0, 0);
        send_frame("u2_75", 8'h75, 0, 0);
        send_frame("wasd_a", 8'h1C, 0, 0);

        // Reset in the middle of a frame.
        ps2_bit(1'b0);
        ps2_bit(1'b1);
        ps2_bit(1'b0);
        do_reset();
        ps2_data = 1'b1;
        repeat (10) @(posedge clock);
        @(negedge clock);
        check_all("midrst");

        // Abandoned frame: no error just before the timeout, one error after it.
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(i[0]);
        repeat (49980) @(posedge clock);
        @(negedge clock);
        chk("to_early_fe", fe_seen, fe_exp);
        repeat (100) @(posedge clock);
        fe_exp++;
        @(negedge clock);
        check_all("to_late");
        send_frame("to_up_e0", 8'hE0, 0, 0);
        send_frame("to_up_75", 8'h75, 0, 0);

        for (int n = 0; n < 40; n++) begin
            send_frame("rnd", pool[$urandom_range(0, 11)],
                       ($urandom_range(0, 9) == 0), ($urandom_range(0, 14) == 0));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
